// File: rtl/branch_stat_ctr.sv
// branch_stat_ctr: saturating branch / BTB-hit / misprediction counters that
// software reads through a 16-bit register window. Reading a *_LO register
// snapshots the whole counter, so the matching *_HI read is tear-free.
module branch_stat_ctr #(
  parameter int unsigned CNT_W     = 32,
  parameter logic [15:0] BASE_ADDR = 16'hC010
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_br_cnt,
  input  logic        inc_hit_cnt,
  input  logic        inc_mispr_cnt,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rd_vld
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int unsigned      HI_W    = CNT_W - 16;

  localparam logic [3:0] OFF_CTRL     = 4'd0;
  localparam logic [3:0] OFF_STATUS   = 4'd1;
  localparam logic [3:0] OFF_BR_LO    = 4'd2;
  localparam logic [3:0] OFF_BR_HI    = 4'd3;
  localparam logic [3:0] OFF_HIT_LO   = 4'd4;
  localparam logic [3:0] OFF_HIT_HI   = 4'd5;
  localparam logic [3:0] OFF_MISPR_LO = 4'd6;
  localparam logic [3:0] OFF_MISPR_HI = 4'd7;

  logic [CNT_W-1:0] br_cnt, hit_cnt, mispr_cnt;
  // Only the upper part of a snapshot is ever read back (the low half is
  // returned live by the *_LO read that takes the snapshot), so only it is kept.
  logic [HI_W-1:0]  br_shd, hit_shd, mispr_shd;
  logic             en;
  logic [2:0]       status;

  logic        sel;
  logic [3:0]  off;
  logic        wr_acc;
  logic        rd_acc;
  logic        clr;
  logic [2:0]  sat_set;
  logic [2:0]  w1c;
  logic [15:0] rd_mux;
  logic        unused_wdata;

  assign sel    = (addr[15:4] == BASE_ADDR[15:4]);
  assign off    = addr[3:0];
  assign wr_acc = sel && we;
  assign rd_acc = sel && re && !we;
  assign clr    = wr_acc && (off == OFF_CTRL) && wdata[1];
  assign w1c    = (wr_acc && (off == OFF_STATUS)) ? wdata[2:0] : 3'b000;

  assign unused_wdata = ^wdata[15:3];

  // Next counter value: clear wins, otherwise increment unless saturated.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic             inc);
    logic [CNT_W-1:0] nxt;
    nxt = cur;
    if (clr)
      nxt = '0;
    else if (inc && en && (cur != CNT_MAX))
      nxt = cur + 1'b1;
    return nxt;
  endfunction

  // Zero-extend the upper counter part to 16 bits.
  function automatic logic [15:0] hi16(input logic [HI_W-1:0] s);
    logic [15:0] h;
    h = '0;
    h[HI_W-1:0] = s;
    return h;
  endfunction

  // Saturation events: an enabled increment arriving while already all-ones.
  always_comb begin
    sat_set    = '0;
    sat_set[0] = !clr && inc_br_cnt    && en && (br_cnt    == CNT_MAX);
    sat_set[1] = !clr && inc_hit_cnt   && en && (hit_cnt   == CNT_MAX);
    sat_set[2] = !clr && inc_mispr_cnt && en && (mispr_cnt == CNT_MAX);
  end

  // Live counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt    <= '0;
      hit_cnt   <= '0;
      mispr_cnt <= '0;
    end else begin
      br_cnt    <= cnt_next(br_cnt,    inc_br_cnt);
      hit_cnt   <= cnt_next(hit_cnt,   inc_hit_cnt);
      mispr_cnt <= cnt_next(mispr_cnt, inc_mispr_cnt);
    end
  end

  // Snapshots: taken on a *_LO read from the pre-increment counter value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_shd    <= '0;
      hit_shd   <= '0;
      mispr_shd <= '0;
    end else if (clr) begin
      br_shd    <= '0;
      hit_shd   <= '0;
      mispr_shd <= '0;
    end else if (rd_acc) begin
      if (off == OFF_BR_LO)    br_shd    <= br_cnt[CNT_W-1:16];
      if (off == OFF_HIT_LO)   hit_shd   <= hit_cnt[CNT_W-1:16];
      if (off == OFF_MISPR_LO) mispr_shd <= mispr_cnt[CNT_W-1:16];
    end
  end

  // Control and sticky status; a new saturation beats a same-cycle w1c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en     <= 1'b1;
      status <= '0;
    end else begin
      if (wr_acc && (off == OFF_CTRL))
        en <= wdata[0];
      status <= (status & ~w1c) | sat_set;
    end
  end

  // Read data selection.
  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:     rd_mux = {15'd0, en};
      OFF_STATUS:   rd_mux = {13'd0, status};
      OFF_BR_LO:    rd_mux = br_cnt[15:0];
      OFF_BR_HI:    rd_mux = hi16(br_shd);
      OFF_HIT_LO:   rd_mux = hit_cnt[15:0];
      OFF_HIT_HI:   rd_mux = hi16(hit_shd);
      OFF_MISPR_LO: rd_mux = mispr_cnt[15:0];
      OFF_MISPR_HI: rd_mux = hi16(mispr_shd);
      default:      rd_mux = '0;
    endcase
  end

  // Registered read port; rdata holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_acc;
      if (rd_acc)
        rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_branch_stat_ctr.sv
// Scoreboard bench for branch_stat_ctr: directed scenarios plus random traffic
// checked against an arithmetic reference model of the register block.
module tb_branch_stat_ctr;

  localparam int unsigned CNT_W = 32;
  localparam logic [15:0] BASE  = 16'hC010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inc_br_cnt = 1'b0, inc_hit_cnt = 1'b0, inc_mispr_cnt = 1'b0;
  logic [15:0] addr = '0;
  logic        re = 1'b0, we = 1'b0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic        rd_vld;

  branch_stat_ctr #(.CNT_W(CNT_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .inc_br_cnt(inc_br_cnt), .inc_hit_cnt(inc_hit_cnt), .inc_mispr_cnt(inc_mispr_cnt),
    .addr(addr), .re(re), .we(we), .wdata(wdata),
    .rdata(rdata), .rd_vld(rd_vld)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [15:0] val; string tag; } exp_t;
  exp_t exp_q[$];

  // Reference model state.
  longint unsigned m_cnt[3];
  longint unsigned m_shd[3];
  bit              m_en;
  bit [2:0]        m_st;
  longint unsigned MAXV = (64'd1 << CNT_W) - 1;

  logic [CNT_W-1:0] force_val;
  logic [15:0]      last_rdata = '0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0;
      m_shd[i] = 0;
    end
    m_en = 1'b1;
    m_st = '0;
  endtask

  // One clock cycle of the register block, expressed from its rules.
  task automatic model_step(input logic [2:0] inc, input logic r, input logic w,
                            input logic [15:0] a, input logic [15:0] d, input string tag);
    bit sel, wr, rd, clr, old_en;
    int off, k;
    bit [2:0] sat;
    exp_t e;
    sel = (a[15:4] == BASE[15:4]);
    off = int'(a[3:0]);
    wr  = sel && w;
    rd  = sel && r && !w;
    if (rd) begin
      e.tag = tag;
      e.val = 16'h0;
      if (off == 0) e.val = {15'd0, m_en};
      else if (off == 1) e.val = {13'd0, m_st};
      else if (off >= 2 && off <= 7) begin
        k = (off - 2) / 2;
        if (off % 2 == 0) e.val = 16'(m_cnt[k] % 65536);
        else              e.val = 16'(m_shd[k] / 65536);
      end
      exp_q.push_back(e);
    end
    clr    = wr && off == 0 && d[1];
    old_en = m_en;
    sat    = '0;
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        m_cnt[i] = 0;
        m_shd[i] = 0;
      end else begin
        if (rd && off == 2 + 2 * i) m_shd[i] = m_cnt[i];
        if (inc[i] && old_en) begin
          if (m_cnt[i] == MAXV) sat[i] = 1'b1;
          else m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
    if (wr && off == 0) m_en = d[0];
    if (wr && off == 1) m_st = m_st & ~d[2:0];
    m_st = m_st | sat;
  endtask

  // Drive one cycle starting from a negedge; returns at the following negedge.
  task automatic step(input logic [2:0] inc, input logic r, input logic w,
                      input logic [15:0] a, input logic [15:0] d, input string tag);
    inc_br_cnt    = inc[0];
    inc_hit_cnt   = inc[1];
    inc_mispr_cnt = inc[2];
    re    = r;
    we    = w;
    addr  = a;
    wdata = d;
    model_step(inc, r, w, a, d, tag);
    @(posedge clk);
    @(negedge clk);
    inc_br_cnt = 1'b0; inc_hit_cnt = 1'b0; inc_mispr_cnt = 1'b0;
    re = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int off, input string tag);
    step(3'b000, 1'b1, 1'b0, BASE + 16'(off), 16'h0, tag);
  endtask

  task automatic wr(input int off, input logic [15:0] d);
    step(3'b000, 1'b0, 1'b1, BASE + 16'(off), d, "wr");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 1'b0, 1'b0, 16'h0, 16'h0, "idle");
  endtask

  // Preload a counter: force across one quiet edge so the register captures it.
  task automatic preload(input int idx, input logic [CNT_W-1:0] v);
    force_val = v;
    case (idx)
      0: force dut.br_cnt = force_val;
      1: force dut.hit_cnt = force_val;
      default: force dut.mispr_cnt = force_val;
    endcase
    @(posedge clk);
    @(negedge clk);
    case (idx)
      0: release dut.br_cnt;
      1: release dut.hit_cnt;
      default: release dut.mispr_cnt;
    endcase
    m_cnt[idx] = longint'(v);
  endtask

  // Monitor: compare every presented read against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rdata = '0;
    end else if (rd_vld) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rd_vld: got rdata 0x%h with no read outstanding (t=%0t)", rdata, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check(e.tag, rdata, e.val);
      end
      last_rdata = rdata;
    end else begin
      check("rdata_hold", rdata, last_rdata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] inc;
    int kind;
    logic [15:0] a, d;

    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rd_vld", {15'd0, rd_vld}, 16'h0);
    check("reset_rdata", rdata, 16'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic counting and snapshot.
    for (int i = 0; i < 5; i++)
      step({i == 0, i < 3, 1'b1}, 1'b0, 1'b0, 16'h0, 16'h0, "inc");
    rd(2, "t1_br_lo");
    rd(3, "t1_br_hi");
    rd(4, "t1_hit_lo");
    rd(6, "t1_mispr_lo");
    rd(0, "t1_ctrl");
    rd(1, "t1_status");

    // Snapshot takes pre-increment value across the 16-bit boundary.
    preload(0, 32'h0000_FFFF);
    step(3'b001, 1'b1, 1'b0, BASE + 16'd2, 16'h0, "t2_br_lo_inc");
    rd(3, "t2_br_hi");
    rd(2, "t2_br_lo_live");
    rd(3, "t2_br_hi_new");

    // Saturation and w1c.
    preload(1, 32'hFFFF_FFFE);
    for (int i = 0; i < 3; i++) step(3'b010, 1'b0, 1'b0, 16'h0, 16'h0, "inc");
    rd(4, "t3_hit_lo");
    rd(5, "t3_hit_hi");
    rd(1, "t3_status_sat");
    wr(1, 16'h0002);
    rd(1, "t3_status_cleared");

    // Disable, then resume.
    wr(0, 16'h0000);
    for (int i = 0; i < 10; i++) step(3'b111, 1'b0, 1'b0, 16'h0, 16'h0, "inc");
    rd(2, "t4_br_lo_frozen");
    rd(6, "t4_mispr_lo_frozen");
    rd(0, "t4_ctrl_off");
    wr(0, 16'h0001);
    for (int i = 0; i < 4; i++) step(3'b101, 1'b0, 1'b0, 16'h0, 16'h0, "inc");
    rd(2, "t4_br_lo_resumed");

    // Clear beats a same-cycle increment.
    step(3'b100, 1'b0, 1'b1, BASE, 16'h0003, "t5_clr");
    rd(6, "t5_mispr_lo");
    rd(7, "t5_mispr_hi");
    rd(0, "t5_ctrl");
    rd(1, "t5_status_kept");

    // Random traffic, with counters parked near interesting boundaries.
    preload(0, CNT_W'(MAXV - 30));
    preload(2, 32'h0001_FFF0);
    for (int n = 0; n < 600; n++) begin
      inc  = 3'($urandom_range(0, 7));
      kind = $urandom_range(0, 9);
      a    = BASE + 16'($urandom_range(0, 15));
      d    = 16'($urandom);
      case (kind)
        0, 1, 2, 3, 4: step(inc, 1'b1, 1'b0, a, 16'h0, "rnd_read");
        5: begin
          a = 16'($urandom);
          if (a[15:4] == BASE[15:4]) a[4] = ~a[4];
          step(inc, 1'b1, $urandom_range(0, 1) == 1, a, d, "rnd_offblock");
        end
        6: step(inc, 1'b0, 1'b1, BASE + 16'd1, d, "rnd_w1c");
        7: begin
          d[0] = ($urandom_range(0, 3) != 0);
          d[1] = ($urandom_range(0, 15) == 0);
          step(inc, 1'b0, 1'b1, BASE, d, "rnd_ctrl");
        end
        8: step(inc, 1'b1, 1'b1, a, d, "rnd_rw");
        default: step(inc, 1'b0, 1'b0, 16'h0, 16'h0, "rnd_idle");
      endcase
    end
    for (int i = 0; i < 8; i++) rd(i, "rnd_final");

    // Reset during a read cycle aborts it.
    idle(1);
    re    = 1'b1;
    addr  = BASE + 16'd2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_read_rd_vld", {15'd0, rd_vld}, 16'h0);
    re    = 1'b0;
    rst_n = 1'b1;
    idle(1);
    check("post_rst_rd_vld", {15'd0, rd_vld}, 16'h0);
    check("post_rst_queue_empty", 16'(exp_q.size()), 16'h0);
    for (int i = 0; i < 16; i++) rd(i, "post_rst_read");
    idle(1);
    step(3'b000, 1'b1, 1'b0, BASE + 16'd16, 16'h0, "offblock_read");
    check("offblock_no_rd_vld", {15'd0, rd_vld}, 16'h0);

    idle(3);
    check("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
